ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side initiator for the single-port synchronous-read RAM (sp_ram): walks an address range and streams the words out over a valid/ready interface.
- Drives the RAM address/write-enable port and accounts for the RAM's one-cycle registered-address read latency.
- Uses a 2-entry output buffer, so downstream backpressure never loses an in-flight word.
- Sits between a RAM instance and any consumer, such as a UART TX or display feeder.

Parameters:
- data_width, 8, width of RAM word and output data
- addr_width, 8, RAM address width; the burst address space is 2**addr_width words

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on clk rising edge
- start  in  1  burst request pulse, sampled only in IDLE
- start_addr  in  addr_width  first address of burst
- len  in  addr_width+1  number of words to read, 0..2**addr_width
- busy  out  1  high from the accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse when the burst completes
- ram_addr  out  addr_width  address to the RAM addr input
- ram_we  out  1  RAM write enable, tied 0
- ram_data_in  out  data_width  RAM data_in, tied 0
- ram_rdata  in  data_width  RAM data_out, equal to mem[address presented the previous cycle]
- m_data  out  data_width  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready; a beat transfers when m_valid && m_ready at a rising edge

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; busy=0, done=0, m_valid=0, m_data=0, ram_addr=0.
  - Buffer count=0, inflight=0, remaining counters=0.
  - Reset mid-burst aborts immediately, drops buffered data, and produces no done pulse.
- States:
  - IDLE: start=1 loads addr_q=start_addr and issue_cnt=len, beat_cnt=len, then goes to READ. If len=0, go to DONE instead.
  - READ: issues reads until issue_cnt=0, then waits until beat_cnt=0, then goes to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- ram_addr=addr_q, a combinational copy of the register.
- Issue condition, evaluated each cycle in READ:
  - issue = (issue_cnt!=0) && (count + inflight - pop) < 2, where pop = m_valid && m_ready.
  - On issue: addr_q <= addr_q+1, wrapping modulo 2**addr_width; issue_cnt decrements; inflight <= 1. Otherwise inflight <= 0.
- Capture: when inflight=1, ram_rdata is pushed into the 2-entry FIFO at that edge. Push and pop in the same cycle are both honoured; count is unchanged.
- Output:
  - m_valid = (count!=0). m_data = FIFO head, registered storage.
  - m_data holds stable while m_valid && !m_ready.
  - beat_cnt decrements on each pop.
- Latency: with start sampled at edge E0 and m_ready=1, m_valid is first high after E2. Sustained throughput is 1 word/clk.
- done asserts in the cycle after the edge that pops the final beat.
- Address wrap: start_addr=2**addr_width-2 with len=4 reads 254, 255, 0, 1 (for addr_width=8).
- len=2**addr_width reads every location once, ending back at start_addr.
- Backpressure: with m_ready=0, at most 2 words are held (count + inflight never exceeds 2) and issuing stalls.

Test Plan:
- Preload mem[i]=i+8'h10; start_addr=5, len=4, m_ready=1 -> m_data 15,16,17,18 on consecutive cycles; m_valid first high 2 edges after start; done pulses once, 1 cycle after the last beat.
- Same preload; start_addr=8'hFE, len=4 -> data 0E,0F,10,11 (addresses 254, 255, 0, 1); ram_addr never leaves 0..255.
- m_ready pattern 1,0,0,1,0,1... over len=6 from addr 0 -> exactly 10,11,12,13,14,15 in order, none dropped or duplicated; m_data stable whenever m_valid && !m_ready; FIFO count never exceeds 2.
- len=0 with start=1 -> no m_valid, ram_we stays 0, done pulses 1 cycle after start, busy high for that cycle only.
- start pulsed again mid-burst (len=8) -> ignored; exactly 8 beats; a new start is accepted only after returning to IDLE.
- rst_n=0 for 1 cycle after 3 of 8 beats -> m_valid=0, busy=0, no done; a new burst start_addr=0, len=2 then returns 10,11 correctly.

Source files
------------

// File: rtl/ram_burst_reader_if.sv
// Bundles the burst control, RAM port and output stream of ram_burst_reader.
interface ram_burst_reader_if #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 8
);
    logic                  start;
    logic [addr_width-1:0] start_addr;
    logic [addr_width:0]   len;
    logic                  busy;
    logic                  done;
    logic [addr_width-1:0] ram_addr;
    logic                  ram_we;
    logic [data_width-1:0] ram_data_in;
    logic [data_width-1:0] ram_rdata;
    logic [data_width-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Reader side: drives the RAM port and the stream.
    modport master (
        input  start, start_addr, len, ram_rdata, m_ready,
        output busy, done, ram_addr, ram_we, ram_data_in, m_data, m_valid
    );

    // Environment side: requester, RAM and stream consumer.
    modport slave (
        output start, start_addr, len, ram_rdata, m_ready,
        input  busy, done, ram_addr, ram_we, ram_data_in, m_data, m_valid
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Walks an address range of a synchronous-read RAM and streams the words out
// over valid/ready, through a 2-entry buffer sized to absorb the read latency.
module ram_burst_reader #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_burst_reader_if.master  bus
);
    localparam int unsigned cnt_width = addr_width + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   load;

    logic [addr_width-1:0]  addr_q;
    logic [cnt_width-1:0]   issue_cnt;
    logic [cnt_width-1:0]   beat_cnt;
    logic                   inflight;

    logic [data_width-1:0]  fifo_mem [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    logic                   pop;
    logic                   push;
    logic                   issue;

    // Handshake and issue qualification; a read is issued only if its word is
    // guaranteed a buffer slot once it returns.
    always_comb begin
        pop   = (count != 2'd0) && bus.m_ready;
        push  = inflight;
        issue = (state == READ) && (issue_cnt != '0) &&
                ((3'(count) + 3'(inflight) - 3'(pop)) < 3'd2);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; READ exits on the edge that pops the final beat.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = (bus.len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if ((beat_cnt == '0) || ((beat_cnt == cnt_width'(1)) && pop)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/counter datapath, read-return tracking and output buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (load) begin
                addr_q    <= bus.start_addr;
                issue_cnt <= bus.len;
                beat_cnt  <= bus.len;
            end else begin
                if (issue) begin
                    addr_q    <= addr_q + addr_width'(1);
                    issue_cnt <= issue_cnt - cnt_width'(1);
                end
                if (pop) begin
                    beat_cnt <= beat_cnt - cnt_width'(1);
                end
            end
            inflight <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= bus.ram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Outputs are direct decodes of registered state.
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.ram_addr    = addr_q;
    assign bus.ram_we      = 1'b0;
    assign bus.ram_data_in = '0;
    assign bus.m_valid     = (count != 2'd0);
    assign bus.m_data      = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader against a behavioural sync-read RAM
// preloaded with mem[i] = i + 8'h10.
module tb_ram_burst_reader;
    localparam int unsigned data_width = 8;
    localparam int unsigned addr_width = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_burst_reader_if #(.data_width(data_width), .addr_width(addr_width)) bus ();

    ram_burst_reader #(.data_width(data_width), .addr_width(addr_width)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM with registered address: data is mem[addr of previous cycle].
    logic [7:0] mem [256];
    always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    logic [7:0] beats [$];
    int   first_valid_edge;
    int   first_pop_edge;
    int   last_pop_edge;
    int   done_edge;
    int   done_cnt;
    int   busy_cycles;
    logic busy_at_done;
    logic we_seen;
    logic valid_seen;
    logic hold_prev;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        first_valid_edge = -1;
        first_pop_edge   = -1;
        last_pop_edge    = -1;
        done_edge        = -1;
        done_cnt         = 0;
        busy_cycles      = 0;
        busy_at_done     = 1'b0;
        we_seen          = 1'b0;
        valid_seen       = 1'b0;
        hold_prev        = 1'b0;
    endtask

    // One clock: observe outputs at the falling edge, return 1 time unit past the rising edge.
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            if (hold_prev)
                check("hold", {23'b0, bus.m_valid, bus.m_data}, {23'b0, 1'b1, prev_data});
            hold_prev = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            if (bus.m_valid) begin
                valid_seen = 1'b1;
                if (first_valid_edge < 0) first_valid_edge = edge_no;
            end
            if (bus.m_valid && bus.m_ready) begin
                beats.push_back(bus.m_data);
                if (first_pop_edge < 0) first_pop_edge = edge_no + 1;
                last_pop_edge = edge_no + 1;
            end
            if (bus.done) begin
                done_cnt++;
                done_edge    = edge_no;
                busy_at_done = bus.busy;
            end
            if (bus.busy) busy_cycles++;
            if (bus.ram_we) we_seen = 1'b1;
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    // Launch a burst and run until the done pulse; rpat is a 6-cycle m_ready pattern.
    task automatic run_burst(input string tag, input logic [7:0] sa, input logic [8:0] ln,
                             input logic [5:0] rpat, input int restart_at, output int e0);
        int k;
        clear_mon();
        bus.start      = 1'b1;
        bus.start_addr = sa;
        bus.len        = ln;
        bus.m_ready    = rpat[0];
        step();
        e0 = edge_no;
        bus.start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            bus.m_ready = rpat[k % 6];
            if (k == restart_at) begin
                bus.start      = 1'b1;
                bus.start_addr = 8'h40;
                bus.len        = 9'd2;
            end else begin
                bus.start = 1'b0;
            end
            step();
            k++;
        end
        bus.start = 1'b0;
        check({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    // Compare collected beats against a run of consecutive expected words.
    task automatic check_beats(input string tag, input logic [7:0] first, input int n);
        logic [7:0] exp_b;
        check({tag, "_nbeats"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            exp_b = first + 8'(i);
            check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp_b));
        end
    endtask

    initial begin
        int e0;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        clear_mon();
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;
        bus.m_ready    = 1'b0;
        step();
        step();
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_m_valid",  32'(bus.m_valid),  32'd0);
        check("rst_m_data",   32'(bus.m_data),   32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_we",   32'(bus.ram_we),   32'd0);
        rst_n = 1'b1;
        step();

        // Basic burst: 15,16,17,18 back to back.
        run_burst("t1", 8'd5, 9'd4, 6'b111111, -1, e0);
        check_beats("t1", 8'h15, 4);
        check("t1_first_valid", 32'(first_valid_edge - e0), 32'd2);
        check("t1_consec",      32'(last_pop_edge - first_pop_edge), 32'd3);
        check("t1_done_cnt",    32'(done_cnt), 32'd1);
        check("t1_done_edge",   32'(done_edge), 32'(last_pop_edge));
        check("t1_busy_done",   32'(busy_at_done), 32'd1);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd7);

        // Address wrap: 254, 255, 0, 1.
        run_burst("t2", 8'hFE, 9'd4, 6'b111111, -1, e0);
        check_beats("t2", 8'h0E, 4);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure with ready pattern 1,0,0,1,0,1.
        run_burst("t3", 8'd0, 9'd6, 6'b101001, -1, e0);
        check_beats("t3", 8'h10, 6);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);
        check("t3_done_edge", 32'(done_edge), 32'(last_pop_edge));

        // Zero-length burst.
        run_burst("t4", 8'd0, 9'd0, 6'b111111, -1, e0);
        check("t4_nbeats",      32'(beats.size()), 32'd0);
        check("t4_valid_seen",  32'(valid_seen), 32'd0);
        check("t4_we_seen",     32'(we_seen), 32'd0);
        check("t4_done_edge",   32'(done_edge - e0), 32'd0);
        check("t4_busy_cycles", 32'(busy_cycles), 32'd1);
        check("t4_done_cnt",    32'(done_cnt), 32'd1);

        // Start re-pulsed mid-burst is ignored; a later start is accepted.
        run_burst("t5", 8'd0, 9'd8, 6'b111111, 2, e0);
        check_beats("t5", 8'h10, 8);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        run_burst("t5b", 8'h40, 9'd2, 6'b111111, -1, e0);
        check_beats("t5b", 8'h50, 2);

        // Reset after 3 of 8 beats aborts cleanly.
        clear_mon();
        bus.start      = 1'b1;
        bus.start_addr = 8'd0;
        bus.len        = 9'd8;
        bus.m_ready    = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0;
        while (beats.size() < 3 && k < 50) begin
            step();
            k++;
        end
        check("t6_three_beats", 32'(beats.size()), 32'd3);
        rst_n = 1'b0;
        step();
        check("t6_m_valid", 32'(bus.m_valid), 32'd0);
        check("t6_busy",    32'(bus.busy),    32'd0);
        check("t6_done",    32'(bus.done),    32'd0);
        check("t6_m_data",  32'(bus.m_data),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_idle_nbeats", 32'(beats.size()), 32'd3);
        run_burst("t6b", 8'd0, 9'd2, 6'b111111, -1, e0);
        check_beats("t6b", 8'h10, 2);
        check("t6b_done_cnt", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
